// File: rtl/knn_topk_core.sv
// K-nearest-neighbour core: squared distance pipeline feeding
// a sorted top-K insertion list with labels.
module knn_topk_core #(
    parameter int COORD_W = 16,
    parameter int K       = 4,
    parameter int LABEL_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              load_test,
    input  logic                              clr,
    input  logic [COORD_W-1:0]                test_x,
    input  logic [COORD_W-1:0]                test_y,
    input  logic                              pt_valid,
    output logic                              pt_ready,
    input  logic [COORD_W-1:0]                pt_x,
    input  logic [COORD_W-1:0]                pt_y,
    input  logic [LABEL_W-1:0]                pt_label,
    output logic [K*(2*COORD_W+2)-1:0]        nbr_dist,
    output logic [K*LABEL_W-1:0]              nbr_label,
    output logic [$clog2(K+1)-1:0]            nbr_count,
    output logic [CNT_W-1:0]                  pt_cnt,
    output logic                              busy
);

    localparam int DIST_W = 2*COORD_W+2;
    localparam int NC_W   = $clog2(K+1);

    logic [COORD_W-1:0]        tx_r, ty_r;
    logic                      s1_v, s2_v;
    logic signed [COORD_W:0]   s1_dx, s1_dy;
    logic [LABEL_W-1:0]        s1_lbl, s2_lbl;
    logic [DIST_W-1:0]         s2_dist;
    logic [DIST_W-1:0]         slot_d [K];
    logic [LABEL_W-1:0]        slot_l [K];
    logic [DIST_W-1:0]         nxt_d  [K];
    logic [LABEL_W-1:0]        nxt_l  [K];
    logic                      ins;

    logic signed [COORD_W:0]   dx_w, dy_w;
    logic signed [DIST_W-1:0]  ex_x, ex_y;
    logic [DIST_W-1:0]         sq_sum;

    assign pt_ready = rst & en & ~load_test & ~clr;
    assign busy     = s1_v | s2_v;

    assign dx_w = {pt_x[COORD_W-1], pt_x} - {tx_r[COORD_W-1], tx_r};
    assign dy_w = {pt_y[COORD_W-1], pt_y} - {ty_r[COORD_W-1], ty_r};

    assign ex_x   = DIST_W'(s1_dx);
    assign ex_y   = DIST_W'(s1_dy);
    assign sq_sum = $unsigned(ex_x * ex_x + ex_y * ex_y);

    // Slot i takes the new point where it first beats the list;
    // every slot after that takes its predecessor.
    always_comb begin
        logic                pv;
        logic                lt;
        logic [DIST_W-1:0]   pd;
        logic [LABEL_W-1:0]  pl;
        pv = 1'b0;
        lt = 1'b0;
        pd = '0;
        pl = '0;
        for (int i = 0; i < K; i++) begin
            lt       = s2_dist < slot_d[i];
            nxt_d[i] = slot_d[i];
            nxt_l[i] = slot_l[i];
            if (pv) begin
                nxt_d[i] = pd;
                nxt_l[i] = pl;
            end else if (lt) begin
                nxt_d[i] = s2_dist;
                nxt_l[i] = s2_lbl;
            end
            pv = lt;
            pd = slot_d[i];
            pl = slot_l[i];
        end
        ins = pv;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_r      <= '0;
            ty_r      <= '0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_lbl    <= '0;
            s2_lbl    <= '0;
            s2_dist   <= '0;
            nbr_count <= '0;
            pt_cnt    <= '0;
            for (int i = 0; i < K; i++) begin
                slot_d[i] <= '1;
                slot_l[i] <= '0;
            end
        end else if (load_test || clr) begin
            if (load_test) begin
                tx_r <= test_x;
                ty_r <= test_y;
            end
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            nbr_count <= '0;
            pt_cnt    <= '0;
            for (int i = 0; i < K; i++) begin
                slot_d[i] <= '1;
                slot_l[i] <= '0;
            end
        end else if (en) begin
            s1_v <= pt_valid;
            if (pt_valid) begin
                s1_dx  <= dx_w;
                s1_dy  <= dy_w;
                s1_lbl <= pt_label;
                pt_cnt <= pt_cnt + CNT_W'(1);
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_dist <= sq_sum;
                s2_lbl  <= s1_lbl;
            end
            if (s2_v) begin
                for (int i = 0; i < K; i++) begin
                    slot_d[i] <= nxt_d[i];
                    slot_l[i] <= nxt_l[i];
                end
                if (ins && nbr_count != NC_W'(K))
                    nbr_count <= nbr_count + NC_W'(1);
            end
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign nbr_dist[g*DIST_W +: DIST_W]   = slot_d[g];
        assign nbr_label[g*LABEL_W +: LABEL_W] = slot_l[g];
    end

endmodule

// File: tb/tb_knn_topk_core.sv
// Bench for knn_topk_core: directed scenarios plus random
// streams checked against a sorted-queue reference model.
module tb_knn_topk_core;

    localparam int CW  = 16;
    localparam int K   = 4;
    localparam int LW  = 8;
    localparam int NW  = 32;
    localparam int DW  = 2*CW+2;
    localparam int NCW = $clog2(K+1);
    localparam logic [63:0] EMPTY = (64'd1 << DW) - 64'd1;

    logic              clk;
    logic              rst;
    logic              en;
    logic              load_test;
    logic              clr;
    logic [CW-1:0]     test_x;
    logic [CW-1:0]     test_y;
    logic              pt_valid;
    logic              pt_ready;
    logic [CW-1:0]     pt_x;
    logic [CW-1:0]     pt_y;
    logic [LW-1:0]     pt_label;
    logic [K*DW-1:0]   nbr_dist;
    logic [K*LW-1:0]   nbr_label;
    logic [NCW-1:0]    nbr_count;
    logic [NW-1:0]     pt_cnt;
    logic              busy;

    knn_topk_core #(
        .COORD_W(CW), .K(K), .LABEL_W(LW), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .load_test(load_test), .clr(clr),
        .test_x(test_x), .test_y(test_y),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_label(pt_label),
        .nbr_dist(nbr_dist), .nbr_label(nbr_label),
        .nbr_count(nbr_count), .pt_cnt(pt_cnt),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        longint d;
        int     l;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sd(input int i);
        return 64'(nbr_dist[i*DW +: DW]);
    endfunction

    function automatic logic [63:0] sl(input int i);
        return 64'(nbr_label[i*LW +: LW]);
    endfunction

    function automatic longint sqd(input int x, input int y,
                                   input int tx, input int ty);
        longint dx;
        longint dy;
        dx = longint'(x) - longint'(tx);
        dy = longint'(y) - longint'(ty);
        return dx*dx + dy*dy;
    endfunction

    // Later equal distances go behind earlier ones.
    task automatic model_ins(input longint d, input int l);
        ent_t e;
        int   idx;
        e.d = d;
        e.l = l;
        idx = 0;
        while (idx < mq.size() && mq[idx].d <= d) idx++;
        mq.insert(idx, e);
        if (mq.size() > K) void'(mq.pop_back());
    endtask

    task automatic check_list(input string tag);
        for (int i = 0; i < K; i++) begin
            if (i < mq.size()) begin
                chk($sformatf("%s_d%0d", tag, i), sd(i), 64'(mq[i].d));
                chk($sformatf("%s_l%0d", tag, i), sl(i), 64'(mq[i].l));
            end else begin
                chk($sformatf("%s_d%0d", tag, i), sd(i), EMPTY);
                chk($sformatf("%s_l%0d", tag, i), sl(i), 64'd0);
            end
        end
        chk({tag, "_cnt"}, 64'(nbr_count), 64'(mq.size()));
    endtask

    task automatic put(input int x, input int y, input int l);
        pt_x     = 16'(x);
        pt_y     = 16'(y);
        pt_label = 8'(l);
    endtask

    task automatic retarget(input int x, input int y);
        test_x    = 16'(x);
        test_y    = 16'(y);
        load_test = 1'b1;
        tick();
        load_test = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c;
        en       = 1'b1;
        pt_valid = 1'b0;
        c        = 0;
        while (busy && c < 10) begin
            tick();
            c++;
        end
        chk({tag, "_drain"}, 64'(busy), 64'd0);
    endtask

    int px[6] = '{3, 1, 0, 10, 0, -2};
    int py[6] = '{4, 1, 5, 0, 0, -2};

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        load_test = 1'b0;
        clr       = 1'b0;
        test_x    = '0;
        test_y    = '0;
        pt_valid  = 1'b1;
        put(7, 7, 3);
        tick();
        tick();
        for (int i = 0; i < K; i++) begin
            chk("rst_dist", sd(i), EMPTY);
            chk("rst_lbl", sl(i), 64'd0);
        end
        chk("rst_count", 64'(nbr_count), 64'd0);
        chk("rst_ptcnt", 64'(pt_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(pt_ready), 64'd0);
        rst      = 1'b1;
        pt_valid = 1'b0;
        #1;
        chk("rel_ready", 64'(pt_ready), 64'd1);

        // sort and ties, test point (0,0)
        for (int j = 0; j < 6; j++) begin
            put(px[j], py[j], j + 1);
            pt_valid = 1'b1;
            tick();
            if (j == 1) chk("lat_e1_cnt", 64'(nbr_count), 64'd0);
            if (j == 2) begin
                chk("lat_e2_cnt", 64'(nbr_count), 64'd1);
                chk("lat_e2_d0", sd(0), 64'd25);
                chk("lat_e2_l0", sl(0), 64'd1);
            end
        end
        pt_valid = 1'b0;
        tick();
        chk("tie_d2", sd(2), 64'd25);
        chk("tie_l2", sl(2), 64'd1);
        chk("tie_d3", sd(3), 64'd25);
        chk("tie_l3", sl(3), 64'd3);
        tick();
        chk("sort_d0", sd(0), 64'd0);
        chk("sort_d1", sd(1), 64'd2);
        chk("sort_d2", sd(2), 64'd8);
        chk("sort_d3", sd(3), 64'd25);
        chk("sort_l0", sl(0), 64'd5);
        chk("sort_l1", sl(1), 64'd2);
        chk("sort_l2", sl(2), 64'd6);
        chk("sort_l3", sl(3), 64'd1);
        chk("sort_cnt", 64'(nbr_count), 64'd4);
        chk("sort_ptcnt", 64'(pt_cnt), 64'd6);
        chk("sort_busy", 64'(busy), 64'd0);

        // extremes
        retarget(-32768, -32768);
        chk("ext_clr_cnt", 64'(nbr_count), 64'd0);
        chk("ext_clr_ptcnt", 64'(pt_cnt), 64'd0);
        put(32767, 32767, 9);
        pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        tick();
        tick();
        chk("ext_d0", sd(0), 64'h1_FFFC_0002);
        chk("ext_l0", sl(0), 64'd9);
        chk("ext_cnt", 64'(nbr_count), 64'd1);

        // stall
        retarget(0, 0);
        put(1, 0, 1);
        pt_valid = 1'b1;
        tick();
        put(2, 0, 2);
        tick();
        en = 1'b0;
        put(50, 50, 9);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_busy", 64'(busy), 64'd1);
            chk("stall_cnt", 64'(nbr_count), 64'd0);
            chk("stall_ready", 64'(pt_ready), 64'd0);
        end
        chk("stall_ptcnt", 64'(pt_cnt), 64'd2);
        pt_valid = 1'b0;
        en       = 1'b1;
        tick();
        chk("unstall_cnt1", 64'(nbr_count), 64'd1);
        chk("unstall_d0", sd(0), 64'd1);
        tick();
        chk("unstall_d1", sd(1), 64'd4);
        chk("unstall_l1", sl(1), 64'd2);
        chk("unstall_cnt2", 64'(nbr_count), 64'd2);
        chk("unstall_ptcnt", 64'(pt_cnt), 64'd2);
        chk("unstall_busy", 64'(busy), 64'd0);

        // clear mid-stream
        for (int j = 1; j <= 3; j++) begin
            put(j, j, 10 + j);
            pt_valid = 1'b1;
            tick();
        end
        clr = 1'b1;
        put(0, 0, 14);
        #1;
        chk("clr_ready", 64'(pt_ready), 64'd0);
        tick();
        clr      = 1'b0;
        pt_valid = 1'b0;
        chk("clr_cnt", 64'(nbr_count), 64'd0);
        chk("clr_ptcnt", 64'(pt_cnt), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        for (int c = 0; c < 3; c++) tick();
        chk("clr_stale_d0", sd(0), EMPTY);
        chk("clr_stale_cnt", 64'(nbr_count), 64'd0);
        chk("clr_stale_ptcnt", 64'(pt_cnt), 64'd0);

        // retarget after a full list
        for (int j = 1; j <= 4; j++) begin
            put(j, 0, j);
            pt_valid = 1'b1;
            tick();
        end
        pt_valid = 1'b0;
        tick();
        tick();
        chk("full_cnt", 64'(nbr_count), 64'd4);
        retarget(5, 5);
        chk("rt_cnt0", 64'(nbr_count), 64'd0);
        put(5, 6, 7);
        pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        tick();
        tick();
        chk("rt_d0", sd(0), 64'd1);
        chk("rt_l0", sl(0), 64'd7);
        chk("rt_d1", sd(1), EMPTY);
        chk("rt_cnt", 64'(nbr_count), 64'd1);
        chk("rt_ptcnt", 64'(pt_cnt), 64'd1);

        // reset mid-stream
        put(1, 1, 1);
        pt_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        pt_valid = 1'b0;
        tick();
        tick();
        chk("mrst_cnt", 64'(nbr_count), 64'd0);
        chk("mrst_d0", sd(0), EMPTY);
        chk("mrst_busy", 64'(busy), 64'd0);

        // random streams
        for (int r = 0; r < 8; r++) begin
            int tx;
            int ty;
            int acc;
            bit wide;
            wide = r[0];
            tx = wide ? int'($urandom_range(0, 65535)) - 32768
                      : int'($urandom_range(0, 20)) - 10;
            ty = wide ? int'($urandom_range(0, 65535)) - 32768
                      : int'($urandom_range(0, 20)) - 10;
            mq.delete();
            retarget(tx, ty);
            acc = 0;
            for (int c = 0; c < 50; c++) begin
                int x;
                int y;
                int l;
                bit v;
                bit e;
                x = wide ? int'($urandom_range(0, 65535)) - 32768
                         : int'($urandom_range(0, 20)) - 10;
                y = wide ? int'($urandom_range(0, 65535)) - 32768
                         : int'($urandom_range(0, 20)) - 10;
                l = int'($urandom_range(0, 255));
                v = ($urandom_range(0, 9) < 7);
                e = ($urandom_range(0, 9) < 8);
                put(x, y, l);
                pt_valid = v;
                en       = e;
                #1;
                chk("rnd_ready", 64'(pt_ready), 64'(e));
                if (v && e) begin
                    model_ins(sqd(x, y, tx, ty), l);
                    acc++;
                end
                tick();
                chk("rnd_ptcnt", 64'(pt_cnt), 64'(acc));
            end
            drain("rnd");
            check_list($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
